// File: rtl/mac_arb_pkg.sv
// Shared types and constants for the two-requester MAC arbiter.
// Optional build macro: MAC_ARB_SAT_EN (saturating accumulation in mac_core).
package mac_arb_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic req_id_t;

  // Round-robin choice: a lone requester wins, on a tie the one not served last wins.
  function automatic req_id_t rr_pick(input logic [1:0] valid, input req_id_t rr_last);
    req_id_t win;
    if (valid == 2'b11) begin
      win = ~rr_last;
    end else if (valid[1]) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/mac_core.sv
// Registered 8x8 unsigned multiply-accumulate with sticky overflow flag.
// Build macro MAC_ARB_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module mac_core
  import mac_arb_pkg::*;
#(
  parameter int unsigned ACC_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic [PROD_W-1:0] prod;
  logic [SUM_W-1:0]  sum;

  // Next accumulator value: clear wins over accumulate; top sum bit is the carry-out.
  always_comb begin
    prod  = PROD_W'(a) * PROD_W'(b);
    sum   = SUM_W'(acc_q) + SUM_W'(prod);
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en) begin
`ifdef MAC_ARB_SAT_EN
      if (sum[ACC_W] || ovf_q) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
`else
      acc_d = sum[ACC_W-1:0];
      if (sum[ACC_W]) begin
        ovf_d = 1'b1;
      end
`endif
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one MAC datapath between two operand streams;
// returns each vector's dot product with requester ID over valid/ready.
// Build macro MAC_ARB_SAT_EN selects saturating accumulation (see mac_core).
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  output logic [1:0]       in_ready,
  input  logic [7:0]       in_a0,
  input  logic [7:0]       in_b0,
  input  logic [7:0]       in_a1,
  input  logic [7:0]       in_b1,
  input  logic [1:0]       in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic             res_id,
  output logic             res_ovf,
  output logic             res_trunc,
  output logic             busy
);

  state_e           state_q, state_d;
  req_id_t          grant_q, grant_d;
  req_id_t          rr_last_q, rr_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic             core_clr, core_en;
  logic [OP_W-1:0]  op_a, op_b;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;

  req_id_t          winner;
  logic             beat, sel_last, at_max, final_beat;
  logic [CNT_W-1:0] cnt_inc;

  // Beat qualification for the granted requester.
  always_comb begin
    winner     = rr_pick(in_valid, rr_last_q);
    op_a       = grant_q ? in_a1 : in_a0;
    op_b       = grant_q ? in_b1 : in_b0;
    sel_last   = in_last[grant_q];
    beat       = (state_q == BUSY) && in_valid[grant_q];
    cnt_inc    = CNT_W'(cnt_q + 1'b1);
    at_max     = (cnt_inc == CNT_W'(MAX_LEN));
    final_beat = beat && (sel_last || at_max);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|in_valid) state_d = BUSY;
      BUSY:    if (final_beat) state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, round-robin pointer, beat counter and accumulator sequencing.
  always_comb begin
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    core_clr  = 1'b0;
    core_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (|in_valid) begin
          grant_d  = winner;
          cnt_d    = '0;
          trunc_d  = 1'b0;
          core_clr = 1'b1;
        end
      end
      BUSY: begin
        if (beat) begin
          cnt_d   = cnt_inc;
          core_en = 1'b1;
          if (at_max && !sel_last) begin
            trunc_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          rr_last_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  // Control registers; rr_last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
    end else begin
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      trunc_q   <= trunc_d;
    end
  end

  mac_core #(
    .ACC_W (ACC_W)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .clr (core_clr),
    .en  (core_en),
    .a   (op_a),
    .b   (op_b),
    .acc (acc),
    .ovf (acc_ovf)
  );

  // Output decode from registered state only.
  always_comb begin
    in_ready  = 2'b00;
    res_valid = 1'b0;
    busy      = (state_q != IDLE);
    if (state_q == BUSY) begin
      in_ready = grant_q ? 2'b10 : 2'b01;
    end
    if (state_q == DONE) begin
      res_valid = 1'b1;
    end
    res_data  = acc;
    res_id    = grant_q;
    res_ovf   = acc_ovf;
    res_trunc = trunc_q;
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed scenarios plus randomized
// two-requester traffic against a per-requester dot-product reference model.
module tb_mac_arbiter;

  localparam int unsigned ACC_W   = 16;
  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned CNT_W   = 5;
  localparam longint      LIMIT   = longint'(1) << ACC_W;

  typedef struct {
    logic [ACC_W-1:0] data;
    logic             ovf;
    logic             trunc;
  } res_t;

  logic             clk;
  logic             rst;
  logic [1:0]       in_valid, in_ready, in_last;
  logic [7:0]       in_a0, in_b0, in_a1, in_b1;
  logic             res_valid, res_ready, res_id, res_ovf, res_trunc, busy;
  logic [ACC_W-1:0] res_data;

  logic             v_r [2];
  logic             l_r [2];
  logic [7:0]       a_r [2];
  logic [7:0]       b_r [2];

  int n_chk, n_fail, n_taken;

  logic [7:0] sa [2][$];
  logic [7:0] sb [2][$];
  logic       sl [2][$];
  res_t       exp_q [2][$];

  assign in_valid = {v_r[1], v_r[0]};
  assign in_last  = {l_r[1], l_r[0]};
  assign in_a0 = a_r[0];
  assign in_b0 = b_r[0];
  assign in_a1 = a_r[1];
  assign in_b1 = b_r[1];

  mac_arbiter #(
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a0     (in_a0),
    .in_b0     (in_b0),
    .in_a1     (in_a1),
    .in_b1     (in_b1),
    .in_last   (in_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf),
    .res_trunc (res_trunc),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one beat on requester r and hold it until accepted; returns just after the accepting edge.
  task automatic drive_beat(input int r, input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    a_r[r] = a;
    b_r[r] = b;
    l_r[r] = last;
    v_r[r] = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = (in_ready[r] === 1'b1);
      @(posedge clk);
      #1;
    end
    v_r[r] = 1'b0;
    l_r[r] = 1'b0;
    check_eq($sformatf("beat_accept_r%0d", r), 32'(ok), 32'd1);
  endtask

  // Wait for a result, check it, optionally stall with res_ready low, then handshake.
  task automatic take_result(input string tag, input logic [ACC_W-1:0] e_data, input logic e_id,
                             input logic e_ovf, input logic e_trunc, input int stall);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      seen = (res_valid === 1'b1);
    end
    check_eq({tag, "_valid"}, 32'(seen), 32'd1);
    check_eq({tag, "_data"}, 32'(res_data), 32'(e_data));
    check_eq({tag, "_id"}, 32'(res_id), 32'(e_id));
    check_eq({tag, "_ovf"}, 32'(res_ovf), 32'(e_ovf));
    check_eq({tag, "_trunc"}, 32'(res_trunc), 32'(e_trunc));
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, 32'(res_valid), 32'd1);
      check_eq({tag, "_stall_data"}, 32'(res_data), 32'(e_data));
      check_eq({tag, "_stall_id"}, 32'(res_id), 32'(e_id));
      check_eq({tag, "_stall_rdy"}, 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    n_taken++;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Build a random beat stream for requester r and derive its expected results:
  // each result is the sum of products up to a last beat or MAX_LEN beats.
  task automatic gen_stream(input int r, input int nvec);
    longint     tot;
    int         cnt, len;
    logic [7:0] a, b;
    logic       last;
    res_t       e;
    tot = 0;
    cnt = 0;
    for (int v = 0; v < nvec; v++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        a = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        b = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(200, 255)) : 8'($urandom_range(0, 255));
        last = (i == len - 1);
        sa[r].push_back(a);
        sb[r].push_back(b);
        sl[r].push_back(last);
        tot += longint'(a) * longint'(b);
        cnt++;
        if (last || cnt == int'(MAX_LEN)) begin
          e.ovf = (tot >= LIMIT);
`ifdef MAC_ARB_SAT_EN
          e.data = e.ovf ? '1 : ACC_W'(tot);
`else
          e.data = ACC_W'(tot);
`endif
          e.trunc = !last;
          exp_q[r].push_back(e);
          tot = 0;
          cnt = 0;
        end
      end
    end
  endtask

  task automatic run_driver(input int r);
    while (sa[r].size() > 0) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      drive_beat(r, sa[r].pop_front(), sb[r].pop_front(), sl[r].pop_front());
    end
  endtask

  // Random-backpressure consumer: checks hold stability and pops the matching requester's queue.
  task automatic run_consumer();
    res_t             e;
    bit               held;
    logic [ACC_W-1:0] hd;
    logic             hid;
    int               cyc;
    held = 1'b0;
    hd   = '0;
    hid  = 1'b0;
    cyc  = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && cyc < 20000) begin
      res_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      cyc++;
      if (res_valid) begin
        if (held) begin
          check_eq("rnd_hold_data", 32'(res_data), 32'(hd));
          check_eq("rnd_hold_id", 32'(res_id), 32'(hid));
        end
        if (res_ready) begin
          check_eq("rnd_q_nonempty", 32'(exp_q[res_id].size() != 0), 32'd1);
          if (exp_q[res_id].size() != 0) begin
            e = exp_q[res_id].pop_front();
            check_eq($sformatf("rnd_data_r%0d", res_id), 32'(res_data), 32'(e.data));
            check_eq($sformatf("rnd_ovf_r%0d", res_id), 32'(res_ovf), 32'(e.ovf));
            check_eq($sformatf("rnd_trunc_r%0d", res_id), 32'(res_trunc), 32'(e.trunc));
          end
          held = 1'b0;
        end else begin
          held = 1'b1;
          hd   = res_data;
          hid  = res_id;
        end
      end
      @(posedge clk);
      #1;
    end
    res_ready = 1'b0;
    check_eq("rnd_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
  endtask

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int t0;
    n_chk = 0;
    n_fail = 0;
    n_taken = 0;
    rst = 1'b1;
    res_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      v_r[r] = 1'b0;
      l_r[r] = 1'b0;
      a_r[r] = 8'd0;
      b_r[r] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_res_data", 32'(res_data), 32'd0);
    check_eq("rst_res_id", 32'(res_id), 32'd0);
    check_eq("rst_res_ovf", 32'(res_ovf), 32'd0);
    check_eq("rst_res_trunc", 32'(res_trunc), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Single requester vector: 6+4+15+14 = 39, result one cycle after the last beat.
    drive_beat(0, 8'd3, 8'd2, 1'b0);
    drive_beat(0, 8'd1, 8'd4, 1'b0);
    drive_beat(0, 8'd5, 8'd3, 1'b0);
    drive_beat(0, 8'd7, 8'd2, 1'b1);
    @(negedge clk);
    check_eq("t1_latency", 32'(res_valid), 32'd1);
    take_result("t1", 16'd39, 1'b0, 1'b0, 1'b0, 0);

    // Both valid from reset: requester 0 first, requester 1 starved meanwhile.
    pulse_reset();
    t0 = n_taken;
    fork
      drive_beat(0, 8'd1, 8'd1, 1'b1);
      drive_beat(1, 8'd2, 8'd3, 1'b1);
      begin
        take_result("t2a", 16'd1, 1'b0, 1'b0, 1'b0, 0);
        take_result("t2b", 16'd6, 1'b1, 1'b0, 1'b0, 0);
      end
      begin
        for (int i = 0; i < 100 && n_taken == t0; i++) begin
          @(negedge clk);
          if (n_taken == t0) check_eq("t2_rdy1_starved", 32'(in_ready[1]), 32'd0);
        end
      end
    join

    // Result back-pressure for 5 cycles, then release: IDLE one cycle, grant the next.
    fork
      drive_beat(0, 8'd2, 8'd2, 1'b1);
      drive_beat(1, 8'd4, 8'd4, 1'b1);
      begin
        take_result("t3a", 16'd4, 1'b0, 1'b0, 1'b0, 5);
        @(negedge clk);
        check_eq("t3_idle_busy", 32'(busy), 32'd0);
        check_eq("t3_idle_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        check_eq("t3_next_grant", 32'(in_ready), 32'd2);
        take_result("t3b", 16'd16, 1'b1, 1'b0, 1'b0, 0);
      end
    join

    // MAX_LEN truncation: 16 beats without last, 17th beat starts a new vector.
    fork
      begin
        for (int i = 0; i < 17; i++) drive_beat(0, 8'd1, 8'd1, 1'(i == 16));
      end
      begin
        take_result("t4a", 16'd16, 1'b0, 1'b0, 1'b1, 2);
        take_result("t4b", 16'd1, 1'b0, 1'b0, 1'b0, 0);
      end
    join

    // Overflow at ACC_W=16: 2*65025 = 130050.
    drive_beat(0, 8'd255, 8'd255, 1'b0);
    drive_beat(0, 8'd255, 8'd255, 1'b1);
`ifdef MAC_ARB_SAT_EN
    take_result("t5", 16'hFFFF, 1'b0, 1'b1, 1'b0, 0);
`else
    take_result("t5", 16'hFC02, 1'b0, 1'b1, 1'b0, 0);
`endif

    // Reset mid-vector discards the partial sum.
    drive_beat(0, 8'd3, 8'd3, 1'b0);
    drive_beat(0, 8'd3, 8'd3, 1'b0);
    pulse_reset();
    @(negedge clk);
    check_eq("t6_busy", 32'(busy), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd0);
    check_eq("t6_res_valid", 32'(res_valid), 32'd0);
    check_eq("t6_res_data", 32'(res_data), 32'd0);
    check_eq("t6_res_id", 32'(res_id), 32'd0);
    check_eq("t6_res_ovf", 32'(res_ovf), 32'd0);
    check_eq("t6_res_trunc", 32'(res_trunc), 32'd0);
    @(posedge clk);
    #1;
    drive_beat(0, 8'd0, 8'd0, 1'b0);
    drive_beat(0, 8'd1, 8'd1, 1'b1);
    take_result("t6", 16'd1, 1'b0, 1'b0, 1'b0, 0);

    // Randomized concurrent traffic from both requesters.
    gen_stream(0, 25);
    gen_stream(1, 25);
    fork
      run_driver(0);
      run_driver(1);
      run_consumer();
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
